// File: rtl/multi_alarm_clock_if.sv
// Signal bundle for multi_alarm_clock: BCD load/readout, alarm controls and status.
// The master drives loads and controls; the slave (the clock) drives time and status.
interface multi_alarm_clock_if #(
    parameter int N_ALARMS = 4
);
    localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic [1:0]          H_in1;
    logic [3:0]          H_in0;
    logic [3:0]          M_in1;
    logic [3:0]          M_in0;
    logic                LD_time;
    logic                LD_alarm;
    logic [SEL_W-1:0]    alarm_sel;
    logic [N_ALARMS-1:0] al_en;
    logic                STOP_al;
    logic                snooze;

    logic [1:0]          H_out1;
    logic [3:0]          H_out0;
    logic [3:0]          M_out1;
    logic [3:0]          M_out0;
    logic [3:0]          S_out1;
    logic [3:0]          S_out0;
    logic                tick_1s;
    logic                Alarm;
    logic [N_ALARMS-1:0] ring_vec;
    logic [SEL_W-1:0]    alarm_id;
    logic                ld_err;

    modport master (
        output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, alarm_sel, al_en, STOP_al, snooze,
        input  H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, tick_1s, Alarm, ring_vec, alarm_id, ld_err
    );

    modport slave (
        input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, alarm_sel, al_en, STOP_al, snooze,
        output H_out1, H_out0, M_out1, M_out0, S_out1, S_out0, tick_1s, Alarm, ring_vec, alarm_id, ld_err
    );
endinterface

// File: rtl/multi_alarm_clock.sv
// BCD time-of-day clock with N independent alarm channels, each with ring timeout and snooze.
// Everything runs on clk; the one-second tick is an enable, never a clock.
module multi_alarm_clock #(
    parameter int CLK_HZ         = 10,
    parameter int N_ALARMS       = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic               clk,
    input  logic               reset_n,
    multi_alarm_clock_if.slave bus
);
    localparam int SEL_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int PRE_W = $clog2(CLK_HZ);
    localparam int RC_W  = $clog2(RING_TIMEOUT_S + 1);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RING_TIMEOUT_S - 1);
    localparam logic [3:0]       SN1     = 4'(SNOOZE_MIN / 10);
    localparam logic [3:0]       SN0     = 4'(SNOOZE_MIN % 10);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    logic [PRE_W-1:0] pre_cnt;
    logic             tick, tick_adv, tick_d;
    logic [1:0]       h1;
    logic [3:0]       h0, m1, m0, s1, s0;
    logic             in_ok, ld_time_ok, ld_alarm_ok, sec_zero;

    assign in_ok = (bus.H_in1 <= 2'd2) && (bus.H_in0 <= 4'd9) &&
                   !((bus.H_in1 == 2'd2) && (bus.H_in0 > 4'd3)) &&
                   (bus.M_in1 <= 4'd5) && (bus.M_in0 <= 4'd9);
    assign ld_time_ok  = bus.LD_time && in_ok;
    assign ld_alarm_ok = bus.LD_alarm && in_ok && (int'(bus.alarm_sel) < N_ALARMS);
    assign tick        = (pre_cnt == PRE_MAX);
    // A time load swallows a coincident tick, so no match can follow a load.
    assign tick_adv    = tick && !ld_time_ok;
    assign sec_zero    = (s1 == 4'd0) && (s0 == 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            tick_d  <= 1'b0;
            h1 <= 2'd0; h0 <= 4'd0; m1 <= 4'd0; m0 <= 4'd0; s1 <= 4'd0; s0 <= 4'd0;
        end else begin
            tick_d <= tick_adv;
            if (ld_time_ok) begin
                pre_cnt <= '0;
                h1 <= bus.H_in1; h0 <= bus.H_in0; m1 <= bus.M_in1; m0 <= bus.M_in0;
                s1 <= 4'd0; s0 <= 4'd0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (tick) begin
                    if (s0 != 4'd9) s0 <= s0 + 4'd1;
                    else begin
                        s0 <= 4'd0;
                        if (s1 != 4'd5) s1 <= s1 + 4'd1;
                        else begin
                            s1 <= 4'd0;
                            if (m0 != 4'd9) m0 <= m0 + 4'd1;
                            else begin
                                m0 <= 4'd0;
                                if (m1 != 4'd5) m1 <= m1 + 4'd1;
                                else begin
                                    m1 <= 4'd0;
                                    if ((h1 == 2'd2) && (h0 == 4'd3)) begin
                                        h1 <= 2'd0; h0 <= 4'd0;
                                    end else if (h0 == 4'd9) begin
                                        h1 <= h1 + 2'd1; h0 <= 4'd0;
                                    end else h0 <= h0 + 4'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Snooze target: digit-wise BCD add of SNOOZE_MIN to the current HH:MM.
    logic [4:0] sm0_sum, sm1_sum;
    logic       c0, c1;
    logic [1:0] sz_h1;
    logic [3:0] sz_h0, sz_m1, sz_m0;

    always_comb begin
        sm0_sum = {1'b0, m0} + {1'b0, SN0};
        c0      = sm0_sum > 5'd9;
        sz_m0   = c0 ? 4'(sm0_sum - 5'd10) : sm0_sum[3:0];
        sm1_sum = {1'b0, m1} + {1'b0, SN1} + {4'd0, c0};
        c1      = sm1_sum > 5'd5;
        sz_m1   = c1 ? 4'(sm1_sum - 5'd6) : sm1_sum[3:0];
        sz_h1   = h1;
        sz_h0   = h0;
        if (c1) begin
            if ((h1 == 2'd2) && (h0 == 4'd3)) begin
                sz_h1 = 2'd0; sz_h0 = 4'd0;
            end else if (h0 == 4'd9) begin
                sz_h1 = h1 + 2'd1; sz_h0 = 4'd0;
            end else sz_h0 = h0 + 4'd1;
        end
    end

    state_t              state_q [N_ALARMS];
    state_t              state_d [N_ALARMS];
    logic [1:0]          al_h1 [N_ALARMS], snz_h1 [N_ALARMS];
    logic [3:0]          al_h0 [N_ALARMS], al_m1 [N_ALARMS], al_m0 [N_ALARMS];
    logic [3:0]          snz_h0 [N_ALARMS], snz_m1 [N_ALARMS], snz_m0 [N_ALARMS];
    logic [RC_W-1:0]     ring_cnt [N_ALARMS];
    logic [N_ALARMS-1:0] match, ring_next;

    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (state_q[i] == SNOOZE)
                match[i] = tick_d && sec_zero && (h1 == snz_h1[i]) && (h0 == snz_h0[i]) &&
                           (m1 == snz_m1[i]) && (m0 == snz_m0[i]);
            else
                match[i] = tick_d && sec_zero && (h1 == al_h1[i]) && (h0 == al_h0[i]) &&
                           (m1 == al_m1[i]) && (m0 == al_m0[i]);
        end
    end

    // Per-channel next state; STOP_al is tested before snooze so it wins.
    always_comb begin
        ring_next = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            state_d[i] = state_q[i];
            if (!bus.al_en[i] || (ld_alarm_ok && (int'(bus.alarm_sel) == i))) state_d[i] = IDLE;
            else begin
                case (state_q[i])
                    IDLE:    if (match[i]) state_d[i] = RING;
                    RING: begin
                        if (bus.STOP_al) state_d[i] = IDLE;
                        else if (bus.snooze) state_d[i] = SNOOZE;
                        else if (tick_adv && (ring_cnt[i] == RC_LAST)) state_d[i] = IDLE;
                    end
                    SNOOZE: begin
                        if (bus.STOP_al) state_d[i] = IDLE;
                        else if (match[i]) state_d[i] = RING;
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
            ring_next[i] = (state_d[i] == RING);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i]  <= IDLE;
                ring_cnt[i] <= '0;
                al_h1[i]  <= 2'd0; al_h0[i]  <= 4'd0; al_m1[i]  <= 4'd0; al_m0[i]  <= 4'd0;
                snz_h1[i] <= 2'd0; snz_h0[i] <= 4'd0; snz_m1[i] <= 4'd0; snz_m0[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                state_q[i] <= state_d[i];
                if (ld_alarm_ok && (int'(bus.alarm_sel) == i)) begin
                    al_h1[i] <= bus.H_in1; al_h0[i] <= bus.H_in0;
                    al_m1[i] <= bus.M_in1; al_m0[i] <= bus.M_in0;
                end
                if ((state_q[i] == RING) && (state_d[i] == SNOOZE)) begin
                    snz_h1[i] <= sz_h1; snz_h0[i] <= sz_h0;
                    snz_m1[i] <= sz_m1; snz_m0[i] <= sz_m0;
                end
                if ((state_d[i] == RING) && (state_q[i] != RING)) ring_cnt[i] <= '0;
                else if ((state_q[i] == RING) && tick_adv) ring_cnt[i] <= ring_cnt[i] + 1'b1;
            end
        end
    end

    logic [SEL_W-1:0]    id_next, alarm_id_q;
    logic [N_ALARMS-1:0] ring_vec_q;
    logic                alarm_q, ld_err_q;

    always_comb begin
        id_next = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (ring_next[i]) id_next = SEL_W'(i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ring_vec_q <= '0;
            alarm_q    <= 1'b0;
            alarm_id_q <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            ring_vec_q <= ring_next;
            alarm_q    <= |ring_next;
            alarm_id_q <= id_next;
            ld_err_q   <= (bus.LD_time && !in_ok) || (bus.LD_alarm && !ld_alarm_ok);
        end
    end

    assign bus.H_out1   = h1;
    assign bus.H_out0   = h0;
    assign bus.M_out1   = m1;
    assign bus.M_out0   = m0;
    assign bus.S_out1   = s1;
    assign bus.S_out0   = s0;
    assign bus.tick_1s  = tick_adv;
    assign bus.Alarm    = alarm_q;
    assign bus.ring_vec = ring_vec_q;
    assign bus.alarm_id = alarm_id_q;
    assign bus.ld_err   = ld_err_q;
endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed self-checking bench for multi_alarm_clock at default parameters.
module tb_multi_alarm_clock;
    localparam int CLK_HZ = 10;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    multi_alarm_clock_if #(.N_ALARMS(4)) bus ();

    multi_alarm_clock #(
        .CLK_HZ(CLK_HZ), .N_ALARMS(4), .SNOOZE_MIN(5), .RING_TIMEOUT_S(60)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] timeNow();
        return {10'd0, bus.H_out1, bus.H_out0, bus.M_out1, bus.M_out0, bus.S_out1, bus.S_out0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives one load cycle from a negedge and returns on the negedge after the load edge.
    task automatic applyStimulus(input logic doTime, input logic doAlarm, input logic [1:0] sel,
                                 input logic [1:0] h1, input logic [3:0] h0,
                                 input logic [3:0] m1, input logic [3:0] m0);
        bus.H_in1 = h1; bus.H_in0 = h0; bus.M_in1 = m1; bus.M_in0 = m0;
        bus.alarm_sel = sel;
        bus.LD_time = doTime;
        bus.LD_alarm = doAlarm;
        @(negedge clk);
        bus.LD_time = 1'b0;
        bus.LD_alarm = 1'b0;
    endtask

    task automatic pulseControl(input logic stop, input logic snz);
        bus.STOP_al = stop;
        bus.snooze = snz;
        @(negedge clk);
        bus.STOP_al = 1'b0;
        bus.snooze = 1'b0;
    endtask

    // Returns on the negedge after the n-th tick, when the advanced time is visible.
    task automatic waitTicks(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = (n + 2) * CLK_HZ;
        while ((seen < n) && (budget > 0)) begin
            @(negedge clk);
            budget--;
            if (bus.tick_1s) seen++;
        end
        if (seen < n) begin
            errors++;
            $display("[TB] FAIL tick_wait: saw %0d ticks, wanted %0d", seen, n);
        end
        @(negedge clk);
    endtask

    // Counts negedges until tick_1s is seen, bounded.
    task automatic cyclesToTick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tick_1s && (n < 3 * CLK_HZ));
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.H_in1 = '0; bus.H_in0 = '0; bus.M_in1 = '0; bus.M_in0 = '0;
        bus.LD_time = 1'b0; bus.LD_alarm = 1'b0; bus.alarm_sel = '0;
        bus.al_en = 4'b0000; bus.STOP_al = 1'b0; bus.snooze = 1'b0;

        #2;
        checkOutput("rst_time", timeNow(), 32'h000000);
        checkOutput("rst_tick", 32'(bus.tick_1s), 0);
        checkOutput("rst_alarm", 32'(bus.Alarm), 0);
        checkOutput("rst_ringvec", 32'(bus.ring_vec), 0);
        checkOutput("rst_id", 32'(bus.alarm_id), 0);
        checkOutput("rst_lderr", 32'(bus.ld_err), 0);

        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.S_out0 != 4'd1) && (n < 3 * CLK_HZ));
        checkOutput("first_second", 32'(n), CLK_HZ);
        cyclesToTick(n);
        cyclesToTick(n);
        checkOutput("tick_spacing_a", 32'(n), CLK_HZ);
        cyclesToTick(n);
        checkOutput("tick_spacing_b", 32'(n), CLK_HZ);

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd2, 4'd3, 4'd5, 4'd9);
        checkOutput("load_2359", timeNow(), 32'h235900);
        checkOutput("load_ok_lderr", 32'(bus.ld_err), 0);
        waitTicks(59);
        checkOutput("time_235959", timeNow(), 32'h235959);
        waitTicks(1);
        checkOutput("wrap_000000", timeNow(), 32'h000000);

        applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 4'd7, 4'd3, 4'd0);
        bus.al_en = 4'b0001;
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 4'd7, 4'd2, 4'd9);
        checkOutput("load_0729", timeNow(), 32'h072900);
        waitTicks(60);
        checkOutput("time_0730", timeNow(), 32'h073000);
        checkOutput("ring_latency", 32'(bus.ring_vec), 0);
        @(negedge clk);
        checkOutput("ch0_ringvec", 32'(bus.ring_vec), 32'h1);
        checkOutput("ch0_alarm", 32'(bus.Alarm), 1);
        checkOutput("ch0_id", 32'(bus.alarm_id), 0);
        waitTicks(59);
        checkOutput("timeout_minus1", 32'(bus.Alarm), 1);
        waitTicks(1);
        checkOutput("timeout_alarm", 32'(bus.Alarm), 0);
        checkOutput("timeout_ringvec", 32'(bus.ring_vec), 0);

        bus.al_en = 4'b0000;
        applyStimulus(1'b0, 1'b1, 2'd1, 2'd0, 4'd6, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 2'd2, 2'd0, 4'd6, 4'd0, 4'd0);
        bus.al_en = 4'b0110;
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 4'd5, 4'd5, 4'd9);
        waitTicks(60);
        @(negedge clk);
        checkOutput("dual_ringvec", 32'(bus.ring_vec), 32'h6);
        checkOutput("dual_id", 32'(bus.alarm_id), 1);
        waitTicks(10);
        checkOutput("time_060010", timeNow(), 32'h060010);
        pulseControl(1'b0, 1'b1);
        checkOutput("dual_snoozed", 32'(bus.Alarm), 0);
        waitTicks(290);
        checkOutput("time_0605", timeNow(), 32'h060500);
        @(negedge clk);
        checkOutput("dual_rering", 32'(bus.ring_vec), 32'h6);
        pulseControl(1'b1, 1'b0);
        checkOutput("dual_stopped", 32'(bus.Alarm), 0);

        bus.al_en = 4'b0000;
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd2, 4'd3, 4'd5, 4'd8);
        bus.al_en = 4'b1000;
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd2, 4'd3, 4'd5, 4'd7);
        waitTicks(60);
        @(negedge clk);
        checkOutput("ch3_ringvec", 32'(bus.ring_vec), 32'h8);
        checkOutput("ch3_id", 32'(bus.alarm_id), 3);
        pulseControl(1'b0, 1'b1);
        checkOutput("ch3_snoozed", 32'(bus.Alarm), 0);
        waitTicks(299);
        checkOutput("time_000259", timeNow(), 32'h000259);
        checkOutput("snooze_early", 32'(bus.Alarm), 0);
        waitTicks(1);
        checkOutput("time_000300", timeNow(), 32'h000300);
        @(negedge clk);
        checkOutput("midnight_rering", 32'(bus.ring_vec), 32'h8);
        pulseControl(1'b1, 1'b0);

        applyStimulus(1'b1, 1'b0, 2'd0, 2'd2, 4'd4, 4'd0, 4'd0);
        checkOutput("bad_time_err", 32'(bus.ld_err), 1);
        checkOutput("bad_time_kept", timeNow(), 32'h000300);
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd1, 4'd2, 4'd6, 4'd0);
        checkOutput("bad_alarm_err", 32'(bus.ld_err), 1);
        @(negedge clk);
        checkOutput("lderr_cleared", 32'(bus.ld_err), 0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd2, 4'd3, 4'd5, 4'd7);
        waitTicks(60);
        @(negedge clk);
        checkOutput("alarm_kept", 32'(bus.ring_vec), 32'h8);
        pulseControl(1'b1, 1'b1);
        checkOutput("stop_over_snooze", 32'(bus.Alarm), 0);
        waitTicks(300);
        checkOutput("time_000300_b", timeNow(), 32'h000300);
        @(negedge clk);
        checkOutput("no_snooze_ring", 32'(bus.Alarm), 0);

        bus.al_en = 4'b0000;
        applyStimulus(1'b0, 1'b1, 2'd0, 2'd1, 4'd0, 4'd0, 4'd0);
        bus.al_en = 4'b0001;
        cyclesToTick(n);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd1, 4'd0, 4'd0, 4'd0);
        checkOutput("load_on_tick", timeNow(), 32'h100000);
        @(negedge clk);
        checkOutput("no_match_on_load", 32'(bus.Alarm), 0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0, 4'd9, 4'd5, 4'd9);
        waitTicks(60);
        @(negedge clk);
        checkOutput("ch0_ring_1000", 32'(bus.Alarm), 1);
        waitTicks(5);
        checkOutput("time_100005", timeNow(), 32'h100005);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_alarm", 32'(bus.Alarm), 0);
        checkOutput("async_rst_ringvec", 32'(bus.ring_vec), 0);
        checkOutput("async_rst_time", timeNow(), 32'h000000);
        @(negedge clk);
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other ports below are synchronous to clk.
REQ-002 Parameter CLK_HZ, default 10: clk cycles per real-time second, minimum 2.
REQ-003 Parameter N_ALARMS, default 4: number of independent alarm channels, range 1-16.
REQ-004 Parameter SNOOZE_MIN, default 5: snooze delay in minutes, range 1-59.
REQ-005 Parameter RING_TIMEOUT_S, default 60: seconds of ringing before automatic stop, minimum 1.
REQ-006 clk  in  1  system clock, CLK_HZ Hz.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 H_in1 in 2, H_in0 in 4, M_in1 in 4, M_in0 in 4  BCD load value HH:MM.
REQ-009 LD_time  in  1  load the time of day from the H_in/M_in inputs.
REQ-010 LD_alarm  in  1  load alarm channel alarm_sel from the H_in/M_in inputs.
REQ-011 alarm_sel  in  max(1,clog2(N_ALARMS))  channel index for LD_alarm.
REQ-012 al_en  in  N_ALARMS  per-channel alarm enable.
REQ-013 STOP_al  in  1  stop all ringing and snoozed channels.
REQ-014 snooze  in  1  snooze all ringing channels.
REQ-015 H_out1 out 2, H_out0 out 4, M_out1 out 4, M_out0 out 4, S_out1 out 4, S_out0 out 4  BCD time of day.
REQ-016 tick_1s  out  1  one-cycle pulse each time the seconds value advances.
REQ-017 Alarm  out  1  high while any channel is in RING.
REQ-018 ring_vec  out  N_ALARMS  per-channel RING indication.
REQ-019 alarm_id  out  max(1,clog2(N_ALARMS))  lowest ringing channel index; 0 when none is ringing.
REQ-020 ld_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-021 Time SHALL be held directly as BCD digits, with no binary-to-BCD division; everything runs on clk, using tick_1s as an enable and no derived clocks.
REQ-022 Prescaler: counts 0..CLK_HZ-1; tick_1s is asserted in the cycle the count wraps from CLK_HZ-1 to 0.
REQ-023 On tick, seconds advance. 59 -> 00 carries to minutes, 59 -> 00 carries to hours, and 23:59:59 -> 00:00:00.
REQ-024 Load validity: the load is invalid if H_in1>2, H_in0>9, H_in1==2 with H_in0>3, M_in1>5, or M_in0>9.
REQ-025 An invalid load is ignored, with ld_err pulsing the next cycle.
REQ-026 Valid LD_time sets HH:MM from the inputs and seconds to 00, and clears the prescaler; it takes priority over a same-cycle tick.
REQ-027 Valid LD_alarm writes channel alarm_sel with HH:MM and forces that channel to IDLE.
REQ-028 LD_time and LD_alarm asserted in the same cycle both take effect.
REQ-029 Each channel SHALL run its own FSM with states IDLE, RING and SNOOZE.
REQ-030 match_i is true when the time is alarm_i HH:MM:00 (in SNOOZE: snooze_i HH:MM:00) and the previous cycle had tick_1s=1.
REQ-031 Because of REQ-030, a match never comes from LD_time alone.
REQ-032 IDLE -> RING on match_i with al_en[i]=1; the RING second counter is cleared on entry.
REQ-033 RING -> SNOOZE on snooze=1, with snooze_i = current HH:MM + SNOOZE_MIN, wrapping through 23:59 to 00:xx.
REQ-034 RING -> IDLE on STOP_al=1, or after RING_TIMEOUT_S ticks spent in RING.
REQ-035 SNOOZE -> RING on match_i, re-arming the timeout; SNOOZE -> IDLE on STOP_al=1.
REQ-036 Any state -> IDLE when al_en[i]=0.
REQ-037 STOP_al has priority over snooze when both are asserted in the same cycle.
REQ-038 The ring_vec, Alarm and alarm_id outputs are registered; a channel's ring_vec bit is set one cycle after its match.

Reset
REQ-039 While reset_n=0, the time is 00:00:00, the prescaler is 0, all alarm and snooze registers are 00:00, all FSMs are IDLE, and tick_1s, Alarm, ring_vec, alarm_id and ld_err are all 0.
REQ-040 Reset asserted mid-ring or mid-load SHALL take effect immediately, without waiting for a clock edge; the first tick after reset_n rises comes CLK_HZ cycles later.

Verification
REQ-041 Load time 23:59 and run 60 ticks -> after the final tick (tick 60) the outputs read 00:00:00; tick_1s is spaced exactly CLK_HZ cycles apart.
REQ-042 Alarm 0 = 07:30, al_en=0001, time loaded 07:29 -> after 60 ticks ring_vec=0001, Alarm=1, alarm_id=0; after RING_TIMEOUT_S further ticks all are 0.
REQ-043 Channels 1 and 2 both = 06:00 and ringing, snooze pulsed at 06:00:10 -> both enter SNOOZE and ring again at 06:05:00; STOP_al at that point -> Alarm=0.
REQ-044 Snooze at 23:58 with SNOOZE_MIN=5 -> the channel re-rings at 00:03:00.
REQ-045 LD_time with 24:00, then LD_alarm with 12:60 -> ld_err pulses twice and time and alarm are unchanged; STOP_al and snooze asserted in the same cycle -> the channel goes IDLE.
REQ-046 reset_n pulsed low while ringing at 10:00:05 -> Alarm, ring_vec and the time clear asynchronously to 0 and 00:00:00.
